// File: rtl/seq_gen_ctrl.sv
// rtl/seq_gen_ctrl.sv - programmable serial sequence generator; optional inter-repetition gap via SEQ_GEN_CTRL_GAP_EN
module seq_gen_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int REP_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [REP_W-1:0]   cfg_rep,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [REP_W-1:0] REP_SAT = '1;

  // Reject parameter sets the length field cannot represent.
  if (MAX_LEN < 2 || MAX_LEN > 31 || ((1 << LEN_W) - 1) < MAX_LEN || GAP_CYC < 1) begin : g_param_check
    $error("seq_gen_ctrl: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               last_rep;

`ifdef SEQ_GEN_CTRL_GAP_EN
  localparam int             GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

  // Pattern bit at a run-time index; shifting avoids an oversized bit-select index.
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // Next-state and registered-output logic for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    rep_d       = rep_q;
    idx_d       = idx_q;
    rep_cnt_d   = rep_cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
`ifdef SEQ_GEN_CTRL_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif
    // Finite mode only: the pattern now ending is the last one requested.
    last_rep = (rep_q != '0) && ((rep_cnt_q + REP_ONE) >= rep_q);

    case (state_q)
      S_IDLE: begin
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = cfg_len;
          rep_d = cfg_rep;
        end
        // Start uses the shadow config as it stood before this edge.
        if (start && !abort) begin
          if (len_q >= LEN_MIN && len_q <= LEN_MAX) begin
            state_d     = S_RUN;
            busy_d      = 1'b1;
            out_valid_d = 1'b1;
            idx_d       = len_q - LEN_ONE;
            out_d       = pat_bit(pat_q, len_q - LEN_ONE);
            rep_cnt_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (cfg_we) begin
          cfg_err_d = 1'b1;
        end
        if (abort) begin
          state_d     = S_IDLE;
          out_d       = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (out_valid_q && out_ready) begin
          if (idx_q != '0) begin
            idx_d = idx_q - LEN_ONE;
            out_d = pat_bit(pat_q, idx_q - LEN_ONE);
          end else begin
            rep_cnt_d = (rep_cnt_q == REP_SAT) ? REP_SAT : rep_cnt_q + REP_ONE;
            if (last_rep) begin
              state_d     = S_IDLE;
              out_d       = 1'b0;
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
            end else begin
`ifdef SEQ_GEN_CTRL_GAP_EN
              state_d     = S_GAP;
              out_d       = 1'b0;
              out_valid_d = 1'b0;
              gap_cnt_d   = GAP_LOAD;
`else
              idx_d = len_q - LEN_ONE;
              out_d = pat_bit(pat_q, len_q - LEN_ONE);
`endif
            end
          end
        end
      end

`ifdef SEQ_GEN_CTRL_GAP_EN
      S_GAP: begin
        if (cfg_we) begin
          cfg_err_d = 1'b1;
        end
        if (abort) begin
          state_d     = S_IDLE;
          out_d       = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (gap_cnt_q == '0) begin
          state_d     = S_RUN;
          out_valid_d = 1'b1;
          idx_d       = len_q - LEN_ONE;
          out_d       = pat_bit(pat_q, len_q - LEN_ONE);
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
`endif

      default: begin
        state_d     = S_IDLE;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, shadow config and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      rep_cnt_q   <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      idx_q       <= idx_d;
      rep_cnt_q   <= rep_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

`ifdef SEQ_GEN_CTRL_GAP_EN
  // Idle-cycle counter for the gap between repetitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// tb/tb_seq_gen_ctrl.sv - vector-table and scoreboard bench for seq_gen_ctrl
`timescale 1ns/1ps
module tb_seq_gen_ctrl;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int REP_W   = 8;
  localparam int GAP_CYC = 2;
`ifdef SEQ_GEN_CTRL_GAP_EN
  localparam int T1_GAP = GAP_CYC;
`else
  localparam int T1_GAP = 0;
`endif

  typedef struct {
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic [REP_W-1:0]   rep;
    bit                 stall;
    bit                 err;
  } rec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [REP_W-1:0]   cfg_rep = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               out_ready = 1'b1;
  logic               out, out_valid, busy, done, cfg_err;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic exp_q[$];
  logic prev_stall = 1'b0;
  logic prev_out = 1'b0;
  rec_t tbl[8];

  seq_gen_ctrl #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_rep(cfg_rep), .start(start), .abort(abort),
    .out_ready(out_ready), .out(out), .out_valid(out_valid), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every transfer pops one expected bit; stalled outputs must hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {30'd0, out_valid, out}, {30'd0, 1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bit: got %0b expected no transfer", out);
        end else begin
          check("stream_bit", {31'd0, out}, {31'd0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic [REP_W-1:0] r);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_rep     = r;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic push_bits(input logic [MAX_LEN-1:0] p, input int l, input int r);
    for (int k = 0; k < r; k++)
      for (int i = l - 1; i >= 0; i--)
        exp_q.push_back(p[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit stall);
    int cyc;
    cyc = 0;
    while (!done && cyc < 2000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_idle"}, {30'd0, busy, out_valid}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic run_rec(input int n, input rec_t r);
    do_cfg(r.pat, r.len, r.rep);
    if (!r.err) push_bits(r.pat, int'(r.len), int'(r.rep));
    out_ready = 1'b1;
    do_start();
    if (r.err) begin
      check($sformatf("rec%0d_err_pulse", n), {30'd0, cfg_err, out_valid}, 32'd2);
      tick();
      check($sformatf("rec%0d_err_clear", n), {29'd0, cfg_err, out_valid, busy}, 32'd0);
    end else begin
      check($sformatf("rec%0d_first", n), {29'd0, busy, out_valid, out}, {29'd0, 2'b11, r.pat[r.len - 1]});
      wait_done($sformatf("rec%0d", n), r.stall);
      tick();
      check($sformatf("rec%0d_done_pulse", n), {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    logic [4:0] p5;
    logic [3:0] p4;
    int         saved;
    p5 = 5'b11001;
    p4 = 4'b1011;

    tbl[0] = '{pat: 16'b11001,            len: 5'd5,  rep: 8'd2, stall: 1'b0, err: 1'b0};
    tbl[1] = '{pat: 16'b11001,            len: 5'd5,  rep: 8'd1, stall: 1'b1, err: 1'b0};
    tbl[2] = '{pat: 16'hA5C3,             len: 5'd16, rep: 8'd1, stall: 1'b0, err: 1'b0};
    tbl[3] = '{pat: 16'b10,               len: 5'd2,  rep: 8'd3, stall: 1'b1, err: 1'b0};
    tbl[4] = '{pat: 16'hFFFF,             len: 5'd0,  rep: 8'd1, stall: 1'b0, err: 1'b1};
    tbl[5] = '{pat: 16'hFFFF,             len: 5'd1,  rep: 8'd1, stall: 1'b0, err: 1'b1};
    tbl[6] = '{pat: 16'hFFFF,             len: 5'd17, rep: 8'd1, stall: 1'b0, err: 1'b1};
    tbl[7] = '{pat: 16'b1010011,          len: 5'd7,  rep: 8'd2, stall: 1'b1, err: 1'b0};

    // Reset state, then a start with the reset (zero) length must be rejected.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, out, out_valid, busy, done, cfg_err}, 32'd0);
    rst = 1'b0;
    tick();
    do_start();
    check("reset_len_err", {30'd0, cfg_err, out_valid}, 32'd2);
    tick();

    for (int n = 0; n < 8; n++) run_rec(n, tbl[n]);

    // Two back-to-back repetitions, cycle-exact timing and done placement.
    do_cfg(16'b11001, 5'd5, 8'd2);
    push_bits(16'b11001, 5, 2);
    out_ready = 1'b1;
    do_start();
    for (int c = 1; c <= 11 + T1_GAP; c++) begin
      logic [3:0] e;
      if (c <= 5) e = {3'b011, p5[5 - c]};
      else if (c <= 5 + T1_GAP) e = 4'b0100;
      else if (c <= 10 + T1_GAP) e = {3'b011, p5[10 + T1_GAP - c]};
      else e = 4'b1000;
      check($sformatf("t1_cycle%0d", c), {28'd0, done, busy, out_valid, out}, {28'd0, e});
      tick();
    end
    check("t1_done_once", {31'd0, done}, 32'd0);

    // Back-pressure after the second transfer holds the third bit.
    do_cfg(16'b11001, 5'd5, 8'd1);
    push_bits(16'b11001, 5, 1);
    out_ready = 1'b1;
    do_start();
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold%0d", k), {30'd0, out_valid, out}, 32'd2);
      tick();
    end
    out_ready = 1'b1;
    wait_done("bp", 1'b0);
    tick();

    // Abort on the seventh transfer of an infinite stream.
    do_cfg(16'b1011, 5'd4, 8'd0);
    for (int j = 0; j < 7; j++) exp_q.push_back(p4[3 - (j % 4)]);
    saved = done_cnt;
    out_ready = 1'b1;
    do_start();
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {29'd0, out_valid, busy, done}, 32'd0);
    check("abort_drained", exp_q.size(), 32'd0);
    tick();
    check("abort_stay_idle", {30'd0, out_valid, busy}, 32'd0);
    check("abort_no_done", done_cnt, saved);

    // Abort together with start in IDLE keeps the block idle.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_idle", {30'd0, busy, out_valid}, 32'd0);
    tick();

    // Config write while running is rejected and leaves the stream alone.
    do_cfg(16'b11001, 5'd5, 8'd1);
    push_bits(16'b11001, 5, 1);
    do_start();
    tick();
    cfg_pattern = 16'hFFFF;
    cfg_len     = 5'd3;
    cfg_rep     = 8'd7;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
    check("run_cfg_err", {30'd0, cfg_err, busy}, 32'd3);
    wait_done("run_cfg", 1'b0);
    // Start in the done cycle is accepted and reuses the unchanged shadow config.
    push_bits(16'b11001, 5, 1);
    do_start();
    check("restart_in_done", {29'd0, busy, out_valid, out}, 32'd7);
    wait_done("restart", 1'b0);
    tick();

    // Asynchronous reset mid-stream clears outputs and shadow config.
    do_cfg(16'b11001, 5'd5, 8'd0);
    push_bits(16'b11001, 5, 2);
    do_start();
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {27'd0, out, out_valid, busy, done, cfg_err}, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    do_start();
    check("post_reset_err", {30'd0, cfg_err, out_valid}, 32'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
